// File: rtl/mac_processing_element.sv
// Pipelined signed MAC cell for weight-stationary systolic arrays: 2-cycle result latency, 1-cycle east forwarding.
// No backpressure; consumers must sample the valids. MAC_SATURATE_EN selects a saturating stage-2 add instead of wrap.
module mac_processing_element #(
   parameter int DATA_WIDTH = 8,
   parameter int SUM_WIDTH  = 2*DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  weight_load,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  input_valid,
   input  logic [DATA_WIDTH-1:0] input_value,
   input  logic [SUM_WIDTH-1:0]  add_value,
   input  logic                  acc_mode,
   input  logic                  acc_clear,
   output logic [DATA_WIDTH-1:0] input_out,
   output logic                  input_valid_out,
   output logic [DATA_WIDTH-1:0] weight_out,
   output logic [SUM_WIDTH-1:0]  output_value,
   output logic                  output_valid
);

   localparam int PW = 2*DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] weight_q, weight_d;
   logic        [DATA_WIDTH-1:0] in_fwd_q;
   logic                         in_vld_fwd_q;
   logic signed [SUM_WIDTH-1:0]  prod_q, prod_d;
   logic signed [SUM_WIDTH-1:0]  addend_q, addend_d;
   logic                         v1_q;
   logic signed [SUM_WIDTH-1:0]  out_q, out_d;
   logic                         out_vld_q;

   logic signed [PW-1:0]         prod_full;
   logic signed [SUM_WIDTH-1:0]  prod_ext;
   logic signed [SUM_WIDTH-1:0]  base;
   logic signed [SUM_WIDTH-1:0]  sum;
   logic signed [SUM_WIDTH-1:0]  result;

   // Full-precision product; both operands sign-extended to PW before multiplying.
   assign prod_full = $signed(input_value) * weight_q;

   generate
      if (SUM_WIDTH > PW) begin : g_prod_sext
         assign prod_ext = {{(SUM_WIDTH-PW){prod_full[PW-1]}}, prod_full};
      end else if (SUM_WIDTH == PW) begin : g_prod_same
         assign prod_ext = prod_full;
      end else begin : g_prod_trunc
         assign prod_ext = prod_full[SUM_WIDTH-1:0];
      end
   endgenerate

   always_comb begin
      weight_d = weight_q;
      if (weight_load) begin
         weight_d = weight_in;
      end
   end

   always_comb begin
      prod_d   = prod_q;
      addend_d = addend_q;
      if (input_valid) begin
         prod_d   = prod_ext;
         addend_d = add_value;
      end
   end

   // A clear alongside accumulation drops the old sum but keeps the incoming product.
   always_comb begin
      base = addend_q;
      if (acc_mode) begin
         base = acc_clear ? '0 : out_q;
      end
   end

   assign sum = base + prod_q;

`ifdef MAC_SATURATE_EN
   logic ovf;
   assign ovf = (base[SUM_WIDTH-1] == prod_q[SUM_WIDTH-1]) &&
                (sum[SUM_WIDTH-1]  != base[SUM_WIDTH-1]);

   always_comb begin
      result = sum;
      if (ovf) begin
         result = base[SUM_WIDTH-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(SUM_WIDTH-1){1'b1}}};
      end
   end
`else
   assign result = sum;
`endif

   always_comb begin
      out_d = out_q;
      if (v1_q) begin
         out_d = result;
      end else if (acc_clear) begin
         out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         weight_q     <= '0;
         in_fwd_q     <= '0;
         in_vld_fwd_q <= 1'b0;
         prod_q       <= '0;
         addend_q     <= '0;
         v1_q         <= 1'b0;
         out_q        <= '0;
         out_vld_q    <= 1'b0;
      end else begin
         weight_q     <= weight_d;
         in_fwd_q     <= input_value;
         in_vld_fwd_q <= input_valid;
         prod_q       <= prod_d;
         addend_q     <= addend_d;
         v1_q         <= input_valid;
         out_q        <= out_d;
         out_vld_q    <= v1_q;
      end
   end

   assign input_out       = in_fwd_q;
   assign input_valid_out = in_vld_fwd_q;
   assign weight_out      = weight_q;
   assign output_value    = out_q;
   assign output_valid    = out_vld_q;

endmodule

// File: tb/tb_mac_processing_element.sv
// Scoreboarded bench for mac_processing_element: directed vectors with hand-computed results.
module tb_mac_processing_element;

   localparam int DW = 8;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          weight_load;
   logic [DW-1:0] weight_in;
   logic          input_valid;
   logic [DW-1:0] input_value;
   logic [SW-1:0] add_value;
   logic          acc_mode;
   logic          acc_clear;
   logic [DW-1:0] input_out;
   logic          input_valid_out;
   logic [DW-1:0] weight_out;
   logic [SW-1:0] output_value;
   logic          output_valid;

   int checks = 0;
   int errors = 0;
   logic [SW-1:0] sb_q[$];

   mac_processing_element #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .weight_load     (weight_load),
      .weight_in       (weight_in),
      .input_valid     (input_valid),
      .input_value     (input_value),
      .add_value       (add_value),
      .acc_mode        (acc_mode),
      .acc_clear       (acc_clear),
      .input_out       (input_out),
      .input_valid_out (input_valid_out),
      .weight_out      (weight_out),
      .output_value    (output_value),
      .output_valid    (output_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Monitor: every valid result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n && output_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h required no output", output_value);
         end else begin
            check("sb_result", {16'h0, output_value}, {16'h0, sb_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      input_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_w(input logic [DW-1:0] w);
      weight_load = 1'b1;
      weight_in   = w;
      tick();
      weight_load = 1'b0;
   endtask

   // Presents one valid input for one edge; leaves input_valid high for back-to-back use.
   task automatic issue(input logic [DW-1:0] x, input logic [SW-1:0] a, input logic [SW-1:0] exp);
      input_valid = 1'b1;
      input_value = x;
      add_value   = a;
      sb_q.push_back(exp);
      tick();
   endtask

   initial begin
      logic [SW-1:0] e_pos_ovf;
      logic [SW-1:0] e_neg_ovf;
      int n;
`ifdef MAC_SATURATE_EN
      e_pos_ovf = 16'h7FFF;
      e_neg_ovf = 16'h8000;
`else
      e_pos_ovf = 16'h8000;
      e_neg_ovf = 16'h7FFF;
`endif
      reset_n     = 1'b0;
      weight_load = 1'b0;
      weight_in   = '0;
      input_valid = 1'b0;
      input_value = '0;
      add_value   = '0;
      acc_mode    = 1'b0;
      acc_clear   = 1'b0;
      #3;
      check("rst_output_value", {16'h0, output_value}, 32'h0);
      check("rst_output_valid", {31'h0, output_valid}, 32'h0);
      check("rst_input_out", {24'h0, input_out}, 32'h0);
      check("rst_input_valid_out", {31'h0, input_valid_out}, 32'h0);
      check("rst_weight_out", {24'h0, weight_out}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Basic MAC and latency: 1 + 2*3 = 7
      load_w(8'd3);
      issue(8'd2, 16'd1, 16'd7);
      input_valid = 1'b0;
      check("lat_not_early", {31'h0, output_valid}, 32'h0);
      tick();
      check("lat_valid", {31'h0, output_valid}, 32'h1);
      check("lat_value", {16'h0, output_value}, 32'd7);
      idle(2);

      // Negative activation and forwarding: 10 + 6*(-1) = 4
      load_w(8'd6);
      issue(8'hFF, 16'd10, 16'd4);
      input_valid = 1'b0;
      check("fwd_input_out", {24'h0, input_out}, 32'hFF);
      check("fwd_input_valid_out", {31'h0, input_valid_out}, 32'h1);
      tick();
      check("fwd_valid_drop", {31'h0, input_valid_out}, 32'h0);
      idle(2);

      // Overflow at both ends of the signed range
      load_w(8'd1);
      issue(8'd1, 16'h7FFF, e_pos_ovf);
      issue(8'hFF, 16'h8000, e_neg_ovf);
      idle(3);

      // Accumulation: clear while idle, then 2, 6, 12, clear with product 10
      load_w(8'd2);
      acc_mode  = 1'b1;
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
      check("acc_clear_idle", {16'h0, output_value}, 32'h0);
      issue(8'd1, 16'h1234, 16'd2);
      issue(8'd2, 16'h1234, 16'd6);
      issue(8'd3, 16'h1234, 16'd12);
      issue(8'd5, 16'h1234, 16'd10);
      input_valid = 1'b0;
      acc_clear   = 1'b1;
      tick();
      acc_clear = 1'b0;
      acc_mode  = 1'b0;
      idle(2);

      // Weight swap on the same edge as an input: old weight 2 -> 8, then 9 -> 36
      weight_load = 1'b1;
      weight_in   = 8'd9;
      issue(8'd4, 16'd0, 16'd8);
      weight_load = 1'b0;
      check("weight_out_new", {24'h0, weight_out}, 32'd9);
      issue(8'd4, 16'd0, 16'd36);
      idle(3);

      // Asynchronous reset with results in flight
      issue(8'd3, 16'd0, 16'd27);
      issue(8'd1, 16'd5, 16'd14);
      input_valid = 1'b0;
      #1;
      reset_n = 1'b0;
      sb_q.delete();
      #1;
      check("arst_output_value", {16'h0, output_value}, 32'h0);
      check("arst_output_valid", {31'h0, output_valid}, 32'h0);
      check("arst_input_valid_out", {31'h0, input_valid_out}, 32'h0);
      check("arst_weight_out", {24'h0, weight_out}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(3);
      check("post_rst_no_valid", {31'h0, output_valid}, 32'h0);

      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("sb_drain", sb_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
